note_pattern_sequencer: RTL and testbench

// - Outbound counterpart of the player-input register: emits the 4-lane note patterns the player must hit.
// - Steps through a fixed 16-entry pattern table and presents one 4-bit pattern per beat.
// - Uses a valid/ready handshake toward the judge/display logic.
// - Records beats that expire without being accepted as misses.

---
 rtl/note_pattern_sequencer_if.sv | 22 ++
 rtl/note_pattern_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_note_pattern_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/note_pattern_sequencer_if.sv
// Pattern handshake bus between the note sequencer (master) and the judge/display logic (slave).
// idx travels with the pattern so the consumer knows which table entry it is seeing.
interface note_pattern_sequencer_if;
  logic [3:0] pattern;
  logic       valid;
  logic       ready;
  logic [3:0] idx;

  modport master (
    output pattern,
    output valid,
    output idx,
    input  ready
  );

  modport slave (
    input  pattern,
    input  valid,
    input  idx,
    output ready
  );
endinterface

// File: rtl/note_pattern_sequencer.sv
// Steps through a fixed 16-entry lane-pattern table, offering each pattern with a
// valid/ready handshake, and counts beats that expire unaccepted as misses.
module note_pattern_sequencer #(
  parameter int LENGTH   = 16,
  parameter int HOLD_CYC = 8,
  parameter int GAP_CYC  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_stop,
  note_pattern_sequencer_if.master    bus,
  output logic                        o_miss,
  output logic [7:0]                  o_misses,
  output logic                        o_busy,
  output logic                        o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_GAP,
    S_FINISH
  } state_t;

  localparam logic [3:0]  LAST_IDX  = 4'(LENGTH - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

  state_t      r_state;
  state_t      w_nextState;

  logic [3:0]  r_pattern;
  logic        r_valid;
  logic [3:0]  r_idx;
  logic        r_miss;
  logic [7:0]  r_misses;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_holdCnt;
  logic [15:0] r_gapCnt;

  logic [3:0]  w_pattern;
  logic        w_valid;
  logic [3:0]  w_idx;
  logic        w_miss;
  logic [7:0]  w_misses;
  logic        w_done;
  logic [15:0] w_holdCnt;
  logic [15:0] w_gapCnt;

  logic [3:0]  w_tablePattern;
  logic        w_abort;
  logic        w_transfer;
  logic        w_expire;
  logic        w_gapDone;

  always_comb begin
    w_tablePattern = 4'h0;
    case (r_idx)
      4'd0:  w_tablePattern = 4'h1;
      4'd1:  w_tablePattern = 4'h2;
      4'd2:  w_tablePattern = 4'h4;
      4'd3:  w_tablePattern = 4'h8;
      4'd4:  w_tablePattern = 4'h3;
      4'd5:  w_tablePattern = 4'hC;
      4'd6:  w_tablePattern = 4'h5;
      4'd7:  w_tablePattern = 4'hA;
      4'd8:  w_tablePattern = 4'h9;
      4'd9:  w_tablePattern = 4'h6;
      4'd10: w_tablePattern = 4'hF;
      4'd11: w_tablePattern = 4'h8;
      4'd12: w_tablePattern = 4'h4;
      4'd13: w_tablePattern = 4'h2;
      4'd14: w_tablePattern = 4'h1;
      4'd15: w_tablePattern = 4'hC;
      default: w_tablePattern = 4'h0;
    endcase
  end

  // A transfer and an expiry on the same edge resolve as a transfer, never a miss.
  assign w_abort    = i_stop && (r_state != S_IDLE);
  assign w_transfer = (r_state == S_PRESENT) && r_valid && bus.ready;
  assign w_expire   = (r_state == S_PRESENT) && (r_holdCnt == HOLD_LAST) && !w_transfer;
  assign w_gapDone  = (r_gapCnt == GAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pattern <= 4'h0;
      r_valid   <= 1'b0;
      r_idx     <= 4'h0;
      r_miss    <= 1'b0;
      r_misses  <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_holdCnt <= 16'h0000;
      r_gapCnt  <= 16'h0000;
    end else begin
      r_state   <= w_nextState;
      r_pattern <= w_pattern;
      r_valid   <= w_valid;
      r_idx     <= w_idx;
      r_miss    <= w_miss;
      r_misses  <= w_misses;
      r_busy    <= (w_nextState != S_IDLE);
      r_done    <= w_done;
      r_holdCnt <= w_holdCnt;
      r_gapCnt  <= w_gapCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (w_abort) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (i_start) w_nextState = S_FETCH;
        S_FETCH:   w_nextState = S_PRESENT;
        S_PRESENT: if (w_transfer || w_expire) w_nextState = S_GAP;
        S_GAP:     if (w_gapDone) w_nextState = (r_idx == LAST_IDX) ? S_FINISH : S_FETCH;
        S_FINISH:  w_nextState = S_IDLE;
        default:   w_nextState = S_IDLE;
      endcase
    end
  end

  // Abort blanks the bus but deliberately leaves idx and the miss count untouched.
  always_comb begin
    w_pattern = r_pattern;
    w_valid   = r_valid;
    w_idx     = r_idx;
    w_miss    = 1'b0;
    w_misses  = r_misses;
    w_done    = 1'b0;
    w_holdCnt = r_holdCnt;
    w_gapCnt  = r_gapCnt;
    if (w_abort) begin
      w_pattern = 4'h0;
      w_valid   = 1'b0;
      w_holdCnt = 16'h0000;
      w_gapCnt  = 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_idx     = 4'h0;
            w_misses  = 8'h00;
            w_holdCnt = 16'h0000;
            w_gapCnt  = 16'h0000;
          end
        end
        S_FETCH: begin
          w_pattern = w_tablePattern;
          w_valid   = 1'b1;
          w_holdCnt = 16'h0000;
        end
        S_PRESENT: begin
          if (w_transfer || w_expire) begin
            w_pattern = 4'h0;
            w_valid   = 1'b0;
            w_holdCnt = 16'h0000;
            w_gapCnt  = 16'h0000;
            if (w_expire) begin
              w_miss   = 1'b1;
              w_misses = (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;
            end
          end else begin
            w_holdCnt = r_holdCnt + 16'd1;
          end
        end
        S_GAP: begin
          if (w_gapDone) begin
            w_gapCnt = 16'h0000;
            if (r_idx != LAST_IDX) w_idx = r_idx + 4'd1;
          end else begin
            w_gapCnt = r_gapCnt + 16'd1;
          end
        end
        S_FINISH: begin
          w_done = 1'b1;
        end
        default: begin
          w_pattern = 4'h0;
          w_valid   = 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern = r_pattern;
  assign bus.valid   = r_valid;
  assign bus.idx     = r_idx;
  assign o_miss      = r_miss;
  assign o_misses    = r_misses;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_note_pattern_sequencer.sv
// Directed bench for note_pattern_sequencer: a 16-entry instance for playback/abort scenarios
// and a 3-entry instance for the all-miss run.
module tb_note_pattern_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start16, stop16, start3, stop3;
  logic       miss16, busy16, done16, miss3, busy3, done3;
  logic [7:0] misses16, misses3;

  int testsRun = 0;
  int testsFailed = 0;

  logic [3:0] expPat [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h5, 4'hA,
                              4'h9, 4'h6, 4'hF, 4'h8, 4'h4, 4'h2, 4'h1, 4'hC};

  note_pattern_sequencer_if bus16();
  note_pattern_sequencer_if bus3();

  always #5 clk = ~clk;

  note_pattern_sequencer #(.LENGTH(16), .HOLD_CYC(8), .GAP_CYC(4)) dut16 (
    .clk(clk), .rst(rst), .i_start(start16), .i_stop(stop16), .bus(bus16),
    .o_miss(miss16), .o_misses(misses16), .o_busy(busy16), .o_done(done16)
  );

  note_pattern_sequencer #(.LENGTH(3), .HOLD_CYC(8), .GAP_CYC(4)) dut3 (
    .clk(clk), .rst(rst), .i_start(start3), .i_stop(stop3), .bus(bus3),
    .o_miss(miss3), .o_misses(misses3), .o_busy(busy3), .o_done(done3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValidIdx16(input logic [3:0] wantIdx, input int maxCyc, output bit found);
    found = 1'b0;
    for (int c = 0; c < maxCyc && !found; c++) begin
      step();
      if (bus16.valid && bus16.idx == wantIdx) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start16 = 1'b1; start3 = 1'b1; stop16 = 1'b0; stop3 = 1'b0;
    bus16.ready = 1'b0; bus3.ready = 1'b0;
    step(); step();
    rst = 1'b0; start16 = 1'b0; start3 = 1'b0;
    testsRun++; if (bus16.pattern !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_o: got %0h expected 0", bus16.pattern); end
    testsRun++; if (bus16.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus16.valid); end
    testsRun++; if (bus16.idx !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_idx: got %0h expected 0", bus16.idx); end
    testsRun++; if (miss16 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_miss: got %0b expected 0", miss16); end
    testsRun++; if (misses16 !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_misses: got %0d expected 0", misses16); end
    testsRun++; if (busy16 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy16); end
    testsRun++; if (done16 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %0b expected 0", done16); end
    testsRun++; if (busy3 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy3: got %0b expected 0", busy3); end
    step();
    testsRun++; if (busy16 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_idle_hold: got busy %0b expected 0", busy16); end
  endtask

  task automatic test_full_run();
    int n, last, doneCnt, missCnt;
    bus16.ready = 1'b1;
    start16 = 1'b1; step(); start16 = 1'b0;
    testsRun++; if (bus16.valid !== 1'b0 || busy16 !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_fetch: got valid %0b busy %0b expected 0 1", bus16.valid, busy16); end
    step();
    testsRun++; if (bus16.valid !== 1'b1 || bus16.pattern !== 4'h1) begin testsFailed++; $display("[TB] FAIL full_first: got valid %0b o %0h expected 1 1", bus16.valid, bus16.pattern); end
    n = 1; last = 0; doneCnt = 0; missCnt = 0;
    for (int c = 1; c <= 110; c++) begin
      step();
      if (miss16) missCnt++;
      if (bus16.valid) begin
        if (n < 16) begin
          testsRun++; if (bus16.pattern !== expPat[n]) begin testsFailed++; $display("[TB] FAIL full_pattern[%0d]: got %0h expected %0h", n, bus16.pattern, expPat[n]); end
        end
        testsRun++; if (c - last != 6) begin testsFailed++; $display("[TB] FAIL full_spacing[%0d]: got %0d expected 6", n, c - last); end
        last = c;
        n++;
      end
      if (done16) begin
        doneCnt++;
        testsRun++; if (misses16 !== 8'h00 || bus16.idx !== 4'hF || busy16 !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_done_state: got misses %0d idx %0h busy %0b expected 0 f 0", misses16, bus16.idx, busy16); end
      end
    end
    testsRun++; if (n != 16) begin testsFailed++; $display("[TB] FAIL full_count: got %0d expected 16", n); end
    testsRun++; if (doneCnt != 1) begin testsFailed++; $display("[TB] FAIL full_done_pulses: got %0d expected 1", doneCnt); end
    testsRun++; if (missCnt != 0) begin testsFailed++; $display("[TB] FAIL full_miss: got %0d expected 0", missCnt); end
  endtask

  task automatic test_backpressure();
    bit sawMiss;
    bus16.ready = 1'b0; sawMiss = 1'b0;
    start16 = 1'b1; step(); start16 = 1'b0;
    step();
    for (int v = 1; v <= 6; v++) begin
      testsRun++; if (bus16.valid !== 1'b1 || bus16.pattern !== 4'h1) begin testsFailed++; $display("[TB] FAIL bp_hold[%0d]: got valid %0b o %0h expected 1 1", v, bus16.valid, bus16.pattern); end
      bus16.ready = (v == 6);
      step();
      if (miss16) sawMiss = 1'b1;
    end
    bus16.ready = 1'b0;
    testsRun++; if (bus16.valid !== 1'b0 || bus16.pattern !== 4'h0) begin testsFailed++; $display("[TB] FAIL bp_transfer: got valid %0b o %0h expected 0 0", bus16.valid, bus16.pattern); end
    testsRun++; if (sawMiss || misses16 !== 8'h00) begin testsFailed++; $display("[TB] FAIL bp_no_miss: got misses %0d expected 0", misses16); end
    stop16 = 1'b1; step(); stop16 = 1'b0;
    testsRun++; if (busy16 !== 1'b0 || bus16.idx !== 4'h0) begin testsFailed++; $display("[TB] FAIL bp_stop: got busy %0b idx %0h expected 0 0", busy16, bus16.idx); end
  endtask

  task automatic test_boundary();
    bit sawMiss;
    bus16.ready = 1'b0; sawMiss = 1'b0;
    start16 = 1'b1; step(); start16 = 1'b0;
    step();
    for (int v = 1; v <= 8; v++) begin
      testsRun++; if (bus16.valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL edge_valid[%0d]: got %0b expected 1", v, bus16.valid); end
      bus16.ready = (v == 8);
      step();
      if (miss16) sawMiss = 1'b1;
    end
    bus16.ready = 1'b0;
    step();
    if (miss16) sawMiss = 1'b1;
    testsRun++; if (sawMiss) begin testsFailed++; $display("[TB] FAIL edge_miss: got 1 expected 0"); end
    testsRun++; if (misses16 !== 8'h00 || bus16.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL edge_transfer: got misses %0d valid %0b expected 0 0", misses16, bus16.valid); end
    stop16 = 1'b1; step(); stop16 = 1'b0;
  endtask

  task automatic test_miss();
    int runLen, runs, missCnt, doneCnt;
    bus3.ready = 1'b0;
    runLen = 0; runs = 0; missCnt = 0; doneCnt = 0;
    start3 = 1'b1; step(); start3 = 1'b0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (bus3.valid) begin
        if (runLen == 0 && runs < 3) begin
          testsRun++; if (bus3.pattern !== expPat[runs]) begin testsFailed++; $display("[TB] FAIL miss_pattern[%0d]: got %0h expected %0h", runs, bus3.pattern, expPat[runs]); end
        end
        runLen++;
      end else if (runLen > 0) begin
        testsRun++; if (runLen != 8) begin testsFailed++; $display("[TB] FAIL miss_valid_len[%0d]: got %0d expected 8", runs, runLen); end
        runs++;
        runLen = 0;
      end
      if (miss3) missCnt++;
      if (done3) begin
        doneCnt++;
        testsRun++; if (misses3 !== 8'd3) begin testsFailed++; $display("[TB] FAIL miss_done_count: got %0d expected 3", misses3); end
      end
    end
    testsRun++; if (runs != 3) begin testsFailed++; $display("[TB] FAIL miss_runs: got %0d expected 3", runs); end
    testsRun++; if (missCnt != 3) begin testsFailed++; $display("[TB] FAIL miss_pulses: got %0d expected 3", missCnt); end
    testsRun++; if (doneCnt != 1) begin testsFailed++; $display("[TB] FAIL miss_done: got %0d expected 1", doneCnt); end
    testsRun++; if (misses3 !== 8'd3 || busy3 !== 1'b0 || bus3.idx !== 4'd2) begin testsFailed++; $display("[TB] FAIL miss_final: got misses %0d busy %0b idx %0h expected 3 0 2", misses3, busy3, bus3.idx); end
  endtask

  task automatic test_abort_restart();
    bit found;
    int doneCnt;
    bus16.ready = 1'b0;
    start16 = 1'b1; step(); start16 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (miss16) found = 1'b1;
    end
    testsRun++; if (!found || misses16 !== 8'd1) begin testsFailed++; $display("[TB] FAIL abort_first_miss: got found %0b misses %0d expected 1 1", found, misses16); end
    bus16.ready = 1'b1;
    waitValidIdx16(4'd2, 40, found);
    testsRun++; if (!found) begin testsFailed++; $display("[TB] FAIL abort_wait_idx2: got timeout expected idx 2 valid"); end
    start16 = 1'b1; step(); start16 = 1'b0;
    waitValidIdx16(4'd3, 20, found);
    testsRun++; if (!found || bus16.pattern !== 4'h8 || busy16 !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_busy_start: got found %0b o %0h busy %0b expected 1 8 1", found, bus16.pattern, busy16); end
    waitValidIdx16(4'd4, 20, found);
    testsRun++; if (!found || bus16.pattern !== 4'h3) begin testsFailed++; $display("[TB] FAIL abort_idx4: got found %0b o %0h expected 1 3", found, bus16.pattern); end
    step();
    testsRun++; if (bus16.valid !== 1'b0 || busy16 !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_in_gap: got valid %0b busy %0b expected 0 1", bus16.valid, busy16); end
    stop16 = 1'b1; step(); stop16 = 1'b0;
    testsRun++; if (busy16 !== 1'b0 || bus16.idx !== 4'd4 || misses16 !== 8'd1 || bus16.valid !== 1'b0 || bus16.pattern !== 4'h0) begin testsFailed++; $display("[TB] FAIL abort_stop: got busy %0b idx %0h misses %0d valid %0b o %0h expected 0 4 1 0 0", busy16, bus16.idx, misses16, bus16.valid, bus16.pattern); end
    doneCnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done16 || busy16) doneCnt++;
    end
    testsRun++; if (doneCnt != 0) begin testsFailed++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", doneCnt); end
    start16 = 1'b1; step(); start16 = 1'b0;
    testsRun++; if (misses16 !== 8'd0 || bus16.idx !== 4'd0 || busy16 !== 1'b1) begin testsFailed++; $display("[TB] FAIL restart_clear: got misses %0d idx %0h busy %0b expected 0 0 1", misses16, bus16.idx, busy16); end
    step();
    testsRun++; if (bus16.valid !== 1'b1 || bus16.pattern !== 4'h1) begin testsFailed++; $display("[TB] FAIL restart_first: got valid %0b o %0h expected 1 1", bus16.valid, bus16.pattern); end
    stop16 = 1'b1; step(); stop16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_backpressure();
    test_boundary();
    test_miss();
    test_abort_restart();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
